keypad_event_tracker: RTL

Parametrised successor to the single-key keypad decoder. It tracks the held state of NUM_KEYS keys at once from the PS/2 scan-code stream (keyCode/make/brakee). It generates press, release and auto-repeat events and buffers them in an event FIFO that game logic pops at its own pace. It sits between the keyboard interface and the game control FSMs.

---
 rtl/keypad_event_tracker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/keypad_event_tracker.sv
// Tracks NUM_KEYS keys from the PS/2 make/break stream. Emits press, release and
// auto-repeat events into a first-word-fall-through FIFO that the game logic drains.
module keypad_event_tracker #(
  parameter int                    NUM_KEYS      = 10,
  parameter logic [NUM_KEYS*9-1:0] KEY_TABLE     = {9'h175, 9'h16b, 9'h172, 9'h174, 9'h01c,
                                                    9'h01d, 9'h01b, 9'h023, 9'h029, 9'h05a},
  parameter int                    FIFO_DEPTH    = 8,
  parameter int                    REPEAT_DELAY  = 25000000,
  parameter int                    REPEAT_PERIOD = 5000000,
  localparam int                   KEY_W         = $clog2(NUM_KEYS),
  localparam int                   CNT_W         = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [8:0]          keyCode,
  input  logic                make,
  input  logic                brakee,
  input  logic                evPop,
  output logic [NUM_KEYS-1:0] keysHeld,
  output logic [CNT_W-1:0]    heldCount,
  output logic [KEY_W-1:0]    lastKey,
  output logic                lastKeyValid,
  output logic                evValid,
  output logic [KEY_W-1:0]    evKey,
  output logic                evRelease,
  output logic                evRepeat,
  output logic                evOverflow
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             rel;
    logic             rep;
  } ev_t;

  logic                hit, held_hit;
  logic [KEY_W-1:0]    idx;
  logic [NUM_KEYS-1:0] sel, held_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                is_press, is_release, rep_fire, push_req, do_push, do_pop, full;
  ev_t                 push_ev, head;
  logic [TMR_W-1:0]    timer;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  ev_t                 mem [FIFO_DEPTH];

  // Scan downwards so the lowest matching table index is the one left standing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    held_hit = 1'b0;
    idx      = '0;
    sel      = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keyCode == KEY_TABLE[(NUM_KEYS-1-i)*9 +: 9]) begin
        hit      = 1'b1;
        held_hit = keysHeld[i];
        idx      = KEY_W'(i);
        sel      = '0;
        sel[i]   = 1'b1;
      end
    end
  end

  // A simultaneous make+break is a break; typematic makes on held keys are silent.
  assign is_press   = make & ~brakee & hit & ~held_hit;
  assign is_release = brakee & hit & held_hit;

  always_comb begin
    held_nxt = keysHeld;
    if (is_press)   held_nxt = keysHeld | sel;
    if (is_release) held_nxt = keysHeld & ~sel;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_KEYS; i++) cnt_nxt = cnt_nxt + CNT_W'(held_nxt[i]);
  end

  // Keyboard events take the FIFO slot; a coinciding repeat is dropped silently.
  assign rep_fire = lastKeyValid & (timer == TMR_W'(1));
  assign push_req = is_press | is_release | rep_fire;
  assign push_ev  = (is_press | is_release) ? ev_t'{key: idx, rel: is_release, rep: 1'b0}
                                            : ev_t'{key: lastKey, rel: 1'b0, rep: 1'b1};

  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign do_pop  = evPop & (count != '0);
  assign do_push = push_req & (~full | do_pop);

  // NOTE: the event storage has no reset; ev* are gated by evValid instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ev;
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      keysHeld     <= '0;
      heldCount    <= '0;
      lastKey      <= '0;
      lastKeyValid <= 1'b0;
      timer        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      evOverflow   <= 1'b0;
    end else begin
      keysHeld  <= held_nxt;
      heldCount <= cnt_nxt;

      if (is_press) begin
        lastKey      <= idx;
        lastKeyValid <= 1'b1;
        timer        <= TMR_W'(REPEAT_DELAY);
      end else if (is_release && idx == lastKey) begin
        lastKeyValid <= 1'b0;
        timer        <= '0;
      end else if (lastKeyValid) begin
        timer <= rep_fire ? TMR_W'(REPEAT_PERIOD) : timer - TMR_W'(1);
      end

      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
      if (push_req && full && !do_pop) evOverflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign evValid   = (count != '0);
  assign evKey     = evValid ? head.key : '0;
  assign evRelease = evValid & head.rel;
  assign evRepeat  = evValid & head.rep;

endmodule
